// File: rtl/uart_rx_oversampler_pkg.sv
// Shared UART definitions: receiver state encoding, default oversample
// ratio (also used by the tx stage and the tick prescaler) and a counter
// width helper.
package uart_rx_oversampler_pkg;

  // Ticks per bit period; the tick prescaler is computed as clk / (baud * this).
  localparam int unsigned UART_OVERSAMPLE = 16;

  // Receiver state encoding.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_rx_state_e;

  // Width of a counter that must hold values 0 .. n-1.
  function automatic int unsigned uart_cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/uart_rx_oversampler_sync_ff.sv
// Multi-flop synchroniser for an asynchronous, idle-high input.
// Flops reset to 1 so a line in its idle state never looks like a start bit.
module uart_rx_oversampler_sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART receiver: synchronises rx, detects the start bit, samples every bit
// at its midpoint using the oversample tick and delivers the byte with a
// one-cycle rx_done pulse, or a one-cycle frame_err pulse on a low stop bit.
module uart_rx_oversampler
  import uart_rx_oversampler_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int unsigned S_W = uart_cnt_width(OVERSAMPLE);
  localparam int unsigned B_W = uart_cnt_width(DATA_BITS) + 32'd1;

  // s_cnt value at the tick that lands mid start bit / at a full bit period.
  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [B_W-1:0] B_LAST = B_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_rx_state_e       state_q, state_d;
  logic [S_W-1:0]       s_cnt_q, s_cnt_d;
  logic [B_W-1:0]       b_cnt_q, b_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  uart_rx_oversampler_sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  // Next-state and output logic of the receive FSM.
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    b_cnt_d = b_cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        // Start detection is immediate; it does not wait for a tick.
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end

      START: begin
        if (tick) begin
          if (s_cnt_q == S_MID) begin
            if (rx_s) begin
              // Line went back high before mid start bit: glitch.
              state_d = IDLE;
              s_cnt_d = '0;
              busy_d  = 1'b0;
            end else begin
              state_d = DATA;
              s_cnt_d = '0;
              b_cnt_d = '0;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end else begin
          s_cnt_d = s_cnt_q;
        end
      end

      DATA: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            // LSB first: each new bit enters at the MSB and moves right.
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            s_cnt_d = '0;
            b_cnt_d = b_cnt_q + B_W'(1);
            if (b_cnt_q == B_LAST) begin
              state_d = STOP;
            end else begin
              state_d = DATA;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end else begin
          s_cnt_d = s_cnt_q;
        end
      end

      STOP: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            if (rx_s) begin
              data_d  = shift_q;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              // Keep the last good byte; stay busy until the line recovers.
              err_d   = 1'b1;
              state_d = WAIT_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end else begin
          s_cnt_d = s_cnt_q;
        end
      end

      WAIT_IDLE: begin
        if (tick && rx_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = WAIT_IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        s_cnt_d = '0;
        b_cnt_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      b_cnt_q <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      b_cnt_q <= b_cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign frame_err = err_q;
  assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Self-checking bench for uart_rx_oversampler: directed scenarios followed by
// randomised frames, checked against a frame-level expectation queue.
module tb_uart_rx_oversampler;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  int vectors     = 0;
  int miscompares = 0;

  int tick_div = 4;
  bit tick_run = 1'b1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_data = 8'h00;
  int         done_seen  = 0;
  int         err_seen   = 0;

  uart_rx_oversampler dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  // Tick generator: one-cycle strobe every tick_div clocks while enabled.
  initial begin
    int tcnt;
    tcnt = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      if (!tick_run) begin
        tick = 1'b0;
      end else begin
        tcnt++;
        if (tcnt >= tick_div) begin
          tick = 1'b1;
          tcnt = 0;
        end else begin
          tick = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    vectors++;
    assert (obs === expd) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
    end
  endtask

  // Monitor: every result pulse must match the next expected frame outcome,
  // and rx_data must always hold the last correctly framed byte.
  always @(negedge clk) begin
    ev_t ev;
    if (reset === 1'b1) begin
      model_data = 8'h00;
    end else begin
      if (rx_done === 1'b1 || frame_err === 1'b1) begin
        check("done_err_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
        if (rx_done === 1'b1) done_seen++;
        if (frame_err === 1'b1) err_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          ev = exp_q.pop_front();
          check("pulse_kind_err", {31'd0, frame_err}, {31'd0, ev.is_err});
          if (!ev.is_err) model_data = ev.data;
        end
      end
      check("rx_data_hold", {24'd0, rx_data}, {24'd0, model_data});
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic send_level(input logic lvl, input int n);
    rx = lvl;
    wait_ticks(n);
    @(negedge clk);
  endtask

  task automatic stall(input int n);
    tick_run = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("stall_busy", {31'd0, rx_busy}, 32'd1);
    end
    tick_run = 1'b1;
  endtask

  // One full frame; stop_ok=0 holds the line low for low_hold ticks instead
  // of a stop bit. stall_bit >= 0 freezes ticks in the middle of that bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input int low_hold, input int stall_bit);
    ev_t ev;
    ev.is_err = !stop_ok;
    ev.data   = b;
    exp_q.push_back(ev);
    send_level(1'b0, OS);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_bit) begin
        send_level(b[i], OS / 2);
        stall(100);
        send_level(b[i], OS / 2);
      end else begin
        send_level(b[i], OS);
      end
    end
    if (stop_ok) send_level(1'b1, OS);
    else send_level(1'b0, low_hold);
    rx = 1'b1;
  endtask

  initial begin
    int d0;
    int e0;
    logic [7:0] b;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_done", {31'd0, rx_done}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    reset = 1'b0;
    send_level(1'b1, 4);

    // Valid byte 0xA5, tick every 4 clk.
    d0 = done_seen; e0 = err_seen;
    send_frame(8'hA5, 1'b1, 0, -1);
    send_level(1'b1, 8);
    check("a5_data", {24'd0, rx_data}, 32'hA5);
    check("a5_done_count", done_seen - d0, 32'd1);
    check("a5_no_err", err_seen - e0, 32'd0);

    // Glitch: three ticks low, then high.
    d0 = done_seen;
    send_level(1'b0, 3);
    check("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
    send_level(1'b1, 16);
    check("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
    check("glitch_no_done", done_seen - d0, 32'd0);
    check("glitch_data", {24'd0, rx_data}, 32'hA5);

    // Framing error: 0x3C with stop low, line held low 40 ticks.
    d0 = done_seen; e0 = err_seen;
    send_frame(8'h3C, 1'b0, 40, -1);
    check("ferr_busy_while_low", {31'd0, rx_busy}, 32'd1);
    check("ferr_err_count", err_seen - e0, 32'd1);
    check("ferr_no_done", done_seen - d0, 32'd0);
    check("ferr_data_kept", {24'd0, rx_data}, 32'hA5);
    send_level(1'b1, 3);
    check("ferr_busy_released", {31'd0, rx_busy}, 32'd0);

    // Back-to-back 0x00 then 0xFF, no idle gap.
    d0 = done_seen;
    send_frame(8'h00, 1'b1, 0, -1);
    send_frame(8'hFF, 1'b1, 0, -1);
    send_level(1'b1, 8);
    check("b2b_done_count", done_seen - d0, 32'd2);
    check("b2b_data", {24'd0, rx_data}, 32'hFF);

    // Reset during bit 4 of 0x5A, then 0x81.
    b = 8'h5A;
    d0 = done_seen; e0 = err_seen;
    send_level(1'b0, OS);
    for (int i = 0; i < 4; i++) send_level(b[i], OS);
    send_level(b[4], OS / 2);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_busy", {31'd0, rx_busy}, 32'd0);
    check("midreset_data", {24'd0, rx_data}, 32'd0);
    reset = 1'b0;
    send_level(1'b1, 20);
    check("midreset_no_output", (done_seen - d0) + (err_seen - e0), 32'd0);
    send_frame(8'h81, 1'b1, 0, -1);
    send_level(1'b1, 8);
    check("after_reset_data", {24'd0, rx_data}, 32'h81);
    check("after_reset_done", done_seen - d0, 32'd1);

    // Tick stall for 100 clk in the middle of data bit 3 of 0x96.
    d0 = done_seen;
    send_frame(8'h96, 1'b1, 0, 3);
    send_level(1'b1, 8);
    check("stall_data", {24'd0, rx_data}, 32'h96);
    check("stall_done", done_seen - d0, 32'd1);

    // Randomised frames, glitches and framing errors at varying tick rates.
    for (int n = 0; n < 40; n++) begin
      int kind;
      tick_div = $urandom_range(1, 5);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        send_level(1'b0, $urandom_range(1, 4));
        send_level(1'b1, 20);
      end else if (kind == 1) begin
        send_frame(8'($urandom), 1'b0, $urandom_range(16, 40), -1);
        send_level(1'b1, 4);
      end else begin
        send_frame(8'($urandom), 1'b1, 0, -1);
        send_level(1'b1, $urandom_range(0, 6));
      end
    end
    send_level(1'b1, 40);
    check("all_frames_accounted", exp_q.size(), 32'd0);
    check("final_idle_busy", {31'd0, rx_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
